// File: rtl/pcie_x1_rx_pkg.sv
// Shared TLP header codes, queue entry layout and credit helper for the
// pcie_x1 VC0 receive credit controller.
package pcie_x1_rx_pkg;

  localparam int unsigned CRED_W = 9;

  localparam logic [4:0] TYPE_MEM   = 5'b00000;
  localparam logic [4:0] TYPE_MEMLK = 5'b00001;
  localparam logic [4:0] TYPE_IO    = 5'b00010;
  localparam logic [4:0] TYPE_CFG0  = 5'b00100;
  localparam logic [4:0] TYPE_CFG1  = 5'b00101;
  localparam logic [4:0] TYPE_CPL   = 5'b01010;
  localparam logic [4:0] TYPE_CPLLK = 5'b01011;
  localparam logic [1:0] TYPE_MSG_PFX = 2'b10;

  typedef enum logic {POSTED, NONPOSTED} tlp_class_e;

  typedef enum logic [1:0] {IDLE, HDR1, BODY} parse_state_e;

  typedef struct packed {
    tlp_class_e        cls;
    logic              hdr;
    logic [CRED_W-1:0] dcred;
    logic              auto_ret;
  } entry_t;

  // Length 0 encodes 1024 DW, i.e. 256 credits.
  function automatic logic [CRED_W-1:0] data_credits(input logic [9:0] len);
    logic [10:0] sum;
    sum = {1'b0, len} + 11'd3;
    if (len == '0) return 9'd256;
    return sum[10:2];
  endfunction

endpackage

// File: rtl/pcie_x1_rx_credit_fifo.sv
// Show-ahead synchronous FIFO holding pending TLP credit entries.
module pcie_x1_rx_credit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_x1_rx_credit_ctrl.sv
// VC0 receive credit controller: parses TLP headers, queues credit costs in
// order and returns them to the core when each TLP is released.
module pcie_x1_rx_credit_ctrl
  import pcie_x1_rx_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic                     sys_clk_125,
  input  logic                     rst_n,
  input  logic [15:0]              rx_data_vc0,
  input  logic                     rx_st_vc0,
  input  logic                     rx_end_vc0,
  input  logic                     rx_us_req_vc0,
  input  logic                     rx_malf_tlp_vc0,
  input  logic                     tlp_release,
  output logic                     ph_processed_vc0,
  output logic                     pd_processed_vc0,
  output logic                     nph_processed_vc0,
  output logic                     npd_processed_vc0,
  output logic [7:0]               pd_num_vc0,
  output logic [7:0]               npd_num_vc0,
  output logic                     ph_buf_status_vc0,
  output logic                     pd_buf_status_vc0,
  output logic                     nph_buf_status_vc0,
  output logic                     npd_buf_status_vc0,
  output logic [$clog2(DEPTH):0]   pending_cnt,
  output logic                     ovf_err,
  output logic                     seq_err
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  parse_state_e state, state_nxt;
  logic [1:0]   fmt_q;
  logic [4:0]   typ_q;
  logic [9:0]   len_q;
  logic         auto_seen;
  logic         flag;
  logic         seq_evt;
  logic         end_evt;
  logic         is_mem, is_msg, is_cpl, is_np;
  entry_t       new_entry;
  entry_t       head;
  logic         wr_en, full, empty, retire;
  logic         split_pend, rel_pend;
  logic         unused_rsvd;

  assign unused_rsvd = rx_data_vc0[15];
  assign flag        = rx_us_req_vc0 | rx_malf_tlp_vc0;

  // rx_st takes priority anywhere outside IDLE: the partial TLP is dropped.
  always_comb begin
    state_nxt = state;
    seq_evt   = 1'b0;
    end_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_st_vc0)  state_nxt = HDR1;
        if (rx_end_vc0) seq_evt   = 1'b1;
      end
      HDR1: begin
        state_nxt = BODY;
        if (rx_st_vc0) begin
          seq_evt   = 1'b1;
          state_nxt = HDR1;
        end
        if (rx_end_vc0) seq_evt = 1'b1;
      end
      BODY: begin
        if (rx_st_vc0) begin
          seq_evt   = 1'b1;
          state_nxt = HDR1;
        end else if (rx_end_vc0) begin
          end_evt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      fmt_q     <= '0;
      typ_q     <= '0;
      len_q     <= '0;
      auto_seen <= 1'b0;
    end else if (rx_st_vc0) begin
      fmt_q     <= rx_data_vc0[14:13];
      typ_q     <= rx_data_vc0[12:8];
      auto_seen <= flag;
    end else begin
      if (state == HDR1) len_q     <= rx_data_vc0[9:0];
      if (state != IDLE) auto_seen <= auto_seen | flag;
    end
  end

  always_comb begin
    is_mem = (typ_q == TYPE_MEM);
    is_msg = (typ_q[4:3] == TYPE_MSG_PFX);
    is_cpl = (typ_q == TYPE_CPL) || (typ_q == TYPE_CPLLK);
    is_np  = (is_mem && !fmt_q[1]) || (typ_q == TYPE_MEMLK) || (typ_q == TYPE_IO)
          || (typ_q == TYPE_CFG0) || (typ_q == TYPE_CFG1);
    new_entry          = '0;
    new_entry.hdr      = 1'b1;
    new_entry.auto_ret = auto_seen | flag;
    if (is_np) begin
      new_entry.cls   = NONPOSTED;
      new_entry.dcred = {8'd0, fmt_q[1]};
    end else begin
      new_entry.cls = POSTED;
      if (((is_mem && fmt_q[1]) || is_msg) && fmt_q[1])
        new_entry.dcred = data_credits(len_q);
    end
  end

  assign wr_en = end_evt && !is_cpl;

  pcie_x1_rx_credit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (sys_clk_125),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (new_entry),
    .rd_en   (retire),
    .rd_data (head),
    .count   (pending_cnt),
    .full    (full),
    .empty   (empty)
  );

  // A 256-credit entry occupies the return path for a second cycle; a release
  // arriving then is carried into the following cycle.
  assign retire = !empty && !split_pend && (head.auto_ret || tlp_release || rel_pend);

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      ph_processed_vc0  <= 1'b0;
      pd_processed_vc0  <= 1'b0;
      nph_processed_vc0 <= 1'b0;
      npd_processed_vc0 <= 1'b0;
      pd_num_vc0        <= '0;
      npd_num_vc0       <= '0;
      split_pend        <= 1'b0;
      rel_pend          <= 1'b0;
    end else begin
      ph_processed_vc0  <= 1'b0;
      pd_processed_vc0  <= 1'b0;
      nph_processed_vc0 <= 1'b0;
      npd_processed_vc0 <= 1'b0;
      pd_num_vc0        <= '0;
      npd_num_vc0       <= '0;
      split_pend        <= 1'b0;
      rel_pend          <= split_pend & tlp_release;
      if (split_pend) begin
        pd_processed_vc0 <= 1'b1;
        pd_num_vc0       <= 8'd128;
      end else if (retire) begin
        if (head.cls == POSTED) begin
          ph_processed_vc0 <= head.hdr;
          if (head.dcred != '0) begin
            pd_processed_vc0 <= 1'b1;
            pd_num_vc0       <= head.dcred[8] ? 8'd128 : head.dcred[7:0];
            split_pend       <= head.dcred[8];
          end
        end else begin
          nph_processed_vc0 <= head.hdr;
          if (head.dcred != '0) begin
            npd_processed_vc0 <= 1'b1;
            npd_num_vc0       <= head.dcred[7:0];
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      ph_buf_status_vc0  <= 1'b0;
      pd_buf_status_vc0  <= 1'b0;
      nph_buf_status_vc0 <= 1'b0;
      npd_buf_status_vc0 <= 1'b0;
      ovf_err            <= 1'b0;
      seq_err            <= 1'b0;
    end else begin
      ph_buf_status_vc0  <= (pending_cnt >= CW'(AFULL_LVL));
      pd_buf_status_vc0  <= (pending_cnt >= CW'(AFULL_LVL));
      nph_buf_status_vc0 <= (pending_cnt >= CW'(AFULL_LVL));
      npd_buf_status_vc0 <= (pending_cnt >= CW'(AFULL_LVL));
      if (wr_en && full) ovf_err <= 1'b1;
      if (seq_evt)       seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_x1_rx_credit_ctrl.sv
// Directed, table-driven bench for pcie_x1_rx_credit_ctrl (DEPTH = 8).
module tb_pcie_x1_rx_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rx_data;
  logic        rx_st, rx_end, rx_us_req, rx_malf, tlp_release;
  logic        ph, pd, nph, npd;
  logic [7:0]  pd_num, npd_num;
  logic        ph_bs, pd_bs, nph_bs, npd_bs;
  logic [3:0]  pending_cnt;
  logic        ovf_err, seq_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #4 clk = ~clk;

  pcie_x1_rx_credit_ctrl #(.DEPTH(8), .AFULL_LVL(7)) dut (
    .sys_clk_125        (clk),
    .rst_n              (rst_n),
    .rx_data_vc0        (rx_data),
    .rx_st_vc0          (rx_st),
    .rx_end_vc0         (rx_end),
    .rx_us_req_vc0      (rx_us_req),
    .rx_malf_tlp_vc0    (rx_malf),
    .tlp_release        (tlp_release),
    .ph_processed_vc0   (ph),
    .pd_processed_vc0   (pd),
    .nph_processed_vc0  (nph),
    .npd_processed_vc0  (npd),
    .pd_num_vc0         (pd_num),
    .npd_num_vc0        (npd_num),
    .ph_buf_status_vc0  (ph_bs),
    .pd_buf_status_vc0  (pd_bs),
    .nph_buf_status_vc0 (nph_bs),
    .npd_buf_status_vc0 (npd_bs),
    .pending_cnt        (pending_cnt),
    .ovf_err            (ovf_err),
    .seq_err            (seq_err)
  );

  typedef struct {
    string       name;
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl [12];

  // {ph, pd, nph, npd, pd_num, npd_num}
  function automatic logic [19:0] mk(input logic eph, input logic epd, input logic enph,
                                     input logic enpd, input logic [7:0] epdn,
                                     input logic [7:0] enpdn);
    return {eph, epd, enph, enpd, epdn, enpdn};
  endfunction

  function automatic logic [19:0] outs();
    return {ph, pd, nph, npd, pd_num, npd_num};
  endfunction

  // {buf_status x4, ovf_err, seq_err, pending_cnt}
  function automatic logic [9:0] stat();
    return {ph_bs, pd_bs, nph_bs, npd_bs, ovf_err, seq_err, pending_cnt};
  endfunction

  function automatic logic [9:0] mks(input logic [3:0] bs, input logic ov, input logic sq,
                                     input logic [3:0] cnt);
    return {bs, ov, sq, cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_data = '0; rx_st = 1'b0; rx_end = 1'b0;
    rx_us_req = 1'b0; rx_malf = 1'b0; tlp_release = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Six-word TLP; bad raises rx_malf_tlp_vc0 on the second body word.
  task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ,
                          input logic [9:0] len, input logic bad);
    rx_data = {1'b0, fmt, typ, 8'h00}; rx_st = 1'b1; tick();
    rx_st = 1'b0; rx_data = {6'd0, len}; tick();
    rx_data = 16'h1234; tick();
    rx_data = 16'h5678; rx_malf = bad; tick();
    rx_malf = 1'b0; rx_data = 16'h9abc; tick();
    rx_data = 16'hdef0; rx_end = 1'b1; tick();
    rx_end = 1'b0; rx_data = '0;
  endtask

  task automatic release_pulse();
    tlp_release = 1'b1; tick(); tlp_release = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"mwr_len4",    2'b10, 5'h00, 10'd4,    mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1,   8'd0)};
    tbl[1]  = '{"mwr4dw_len5", 2'b11, 5'h00, 10'd5,    mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd2,   8'd0)};
    tbl[2]  = '{"mrd_len16",   2'b00, 5'h00, 10'd16,   mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0)};
    tbl[3]  = '{"cfgwr0",      2'b10, 5'h04, 10'd1,    mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd1)};
    tbl[4]  = '{"iowr",        2'b10, 5'h02, 10'd1,    mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd1)};
    tbl[5]  = '{"msgd_len3",   2'b11, 5'h13, 10'd3,    mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1,   8'd0)};
    tbl[6]  = '{"msg_nodata",  2'b01, 5'h14, 10'd0,    mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0)};
    tbl[7]  = '{"other_type",  2'b10, 5'h1f, 10'd8,    mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0)};
    tbl[8]  = '{"mwr_len1020", 2'b10, 5'h00, 10'd1020, mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0)};
    tbl[9]  = '{"mrdlk",       2'b00, 5'h01, 10'd2,    mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0)};
    tbl[10] = '{"cfgrd1",      2'b00, 5'h05, 10'd1,    mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd0)};
    tbl[11] = '{"mwr_len7",    2'b10, 5'h00, 10'd7,    mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd2,   8'd0)};

    do_reset();
    check("reset_outs", 32'(outs()), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0)));
    check("reset_stat", 32'(stat()), 32'(mks(4'b0000, 1'b0, 1'b0, 4'd0)));

    for (int i = 0; i < 12; i++) begin
      send_tlp(tbl[i].fmt, tbl[i].typ, tbl[i].len, 1'b0);
      check({tbl[i].name, "_queued"}, 32'(pending_cnt), 32'd1);
      check({tbl[i].name, "_hold"}, 32'(outs()), 32'd0);
      release_pulse();
      check({tbl[i].name, "_pulse"}, 32'(outs()), 32'(tbl[i].exp));
      tick();
      check({tbl[i].name, "_after"}, 32'(outs()), 32'd0);
      check({tbl[i].name, "_drained"}, 32'(pending_cnt), 32'd0);
    end

    // 256-credit split with a second TLP released during the first half.
    send_tlp(2'b10, 5'h00, 10'd0, 1'b0);
    send_tlp(2'b10, 5'h00, 10'd4, 1'b0);
    check("split_queued", 32'(pending_cnt), 32'd2);
    release_pulse();
    check("split_n", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd128, 8'd0)));
    tlp_release = 1'b1;
    tick();
    tlp_release = 1'b0;
    check("split_n1", 32'(outs()), 32'(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd128, 8'd0)));
    tick();
    check("split_n2", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0)));
    tick();
    check("split_idle", 32'(outs()), 32'd0);
    check("split_drained", 32'(pending_cnt), 32'd0);

    // Malformed MRd retires by itself; MWr behind it waits for a release.
    send_tlp(2'b00, 5'h00, 10'd4, 1'b1);
    tick();
    check("auto_pulse", 32'(outs()), 32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0)));
    check("auto_drained", 32'(pending_cnt), 32'd0);
    release_pulse();
    check("empty_release", 32'(outs()), 32'd0);
    send_tlp(2'b10, 5'h00, 10'd4, 1'b0);
    tick();
    tick();
    check("mwr_waits_cnt", 32'(pending_cnt), 32'd1);
    check("mwr_waits_outs", 32'(outs()), 32'd0);
    release_pulse();
    check("mwr_released", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0)));

    // Framing errors.
    do_reset();
    rx_end = 1'b1; tick(); rx_end = 1'b0;
    check("end_in_idle", 32'(stat()), 32'(mks(4'b0000, 1'b0, 1'b1, 4'd0)));
    do_reset();
    rx_data = {1'b0, 2'b10, 5'h00, 8'h00}; rx_st = 1'b1; tick();
    rx_st = 1'b0; rx_data = 16'd4; tick();
    rx_data = 16'h1111; tick();
    send_tlp(2'b00, 5'h00, 10'd1, 1'b0);
    check("restart_stat", 32'(stat()), 32'(mks(4'b0000, 1'b0, 1'b1, 4'd1)));
    release_pulse();
    check("restart_head", 32'(outs()), 32'(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0)));

    // Completions, almost-full and overflow.
    do_reset();
    send_tlp(2'b10, 5'h0a, 10'd4, 1'b0);
    tick();
    check("cpld_stat", 32'(stat()), 32'd0);
    check("cpld_outs", 32'(outs()), 32'd0);
    for (int i = 0; i < 7; i++) send_tlp(2'b10, 5'h00, 10'd4, 1'b0);
    check("fill7_now", 32'(stat()), 32'(mks(4'b0000, 1'b0, 1'b0, 4'd7)));
    tick();
    check("fill7_afull", 32'(stat()), 32'(mks(4'b1111, 1'b0, 1'b0, 4'd7)));
    send_tlp(2'b10, 5'h00, 10'd4, 1'b0);
    check("fill8", 32'(stat()), 32'(mks(4'b1111, 1'b0, 1'b0, 4'd8)));
    send_tlp(2'b10, 5'h00, 10'd4, 1'b0);
    check("overflow", 32'(stat()), 32'(mks(4'b1111, 1'b1, 1'b0, 4'd8)));

    // Reset in the middle of a split return: no trailing pulse.
    do_reset();
    send_tlp(2'b10, 5'h00, 10'd0, 1'b0);
    release_pulse();
    check("rst_split_first", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd128, 8'd0)));
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_no_tail", 32'(outs()), 32'd0);

    // Reset in the middle of a TLP with one entry queued.
    send_tlp(2'b00, 5'h00, 10'd1, 1'b0);
    rx_data = {1'b0, 2'b10, 5'h00, 8'h00}; rx_st = 1'b1; tick();
    rx_st = 1'b0; rx_data = 16'd4; tick();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_stat", 32'(stat()), 32'd0);
    check("rst_mid_outs", 32'(outs()), 32'd0);
    tick();
    rst_n = 1'b1;
    send_tlp(2'b10, 5'h00, 10'd8, 1'b0);
    check("post_rst_cnt", 32'(stat()), 32'(mks(4'b0000, 1'b0, 1'b0, 4'd1)));
    release_pulse();
    check("post_rst_pulse", 32'(outs()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_x1_rx_credit_ctrl.md
Name: pcie_x1_rx_credit_ctrl

Overview:
- Sits directly downstream of the pcie_x1 core receive interface (VC0) in the 125 MHz domain.
- Decodes each received TLP header from the 16-bit rx_data_vc0 stream and queues its credit cost, in order.
- Returns the credits to the core via the *_processed_vc0 / *_num_vc0 inputs once user logic releases the TLP.
- Drives the core's *_buf_status_vc0 inputs from queue occupancy.

Parameters:
- DEPTH, 8, pending-TLP queue entries (power of two, 4..32).
- AFULL_LVL, DEPTH-1, occupancy at or above which all four buf_status outputs assert.

Ports:
- sys_clk_125 in 1: core 125 MHz clock, sole clock.
- rst_n in 1: asynchronous active-low reset.
- rx_data_vc0 in 16: TLP data from core.
- rx_st_vc0 in 1: first word of TLP.
- rx_end_vc0 in 1: last word of TLP.
- rx_us_req_vc0 in 1: unsupported request flag from core.
- rx_malf_tlp_vc0 in 1: malformed TLP flag from core.
- tlp_release in 1: user has finished the head non-auto TLP (one pulse per TLP).
- ph_processed_vc0 out 1: posted header credit return pulse.
- pd_processed_vc0 out 1: posted data credit return pulse.
- nph_processed_vc0 out 1: non-posted header credit return pulse.
- npd_processed_vc0 out 1: non-posted data credit return pulse.
- pd_num_vc0 out 8: posted data credits returned with pd_processed_vc0.
- npd_num_vc0 out 8: non-posted data credits returned with npd_processed_vc0.
- ph_buf_status_vc0 out 1: queue almost full.
- pd_buf_status_vc0 out 1: queue almost full.
- nph_buf_status_vc0 out 1: queue almost full.
- npd_buf_status_vc0 out 1: queue almost full.
- pending_cnt out $clog2(DEPTH)+1: queue occupancy.
- ovf_err out 1: sticky queue overflow.
- seq_err out 1: sticky framing error.

Behaviour:
- Reset: all outputs 0, pd_num/npd_num 0, queue empty, parser IDLE. Reset mid-packet or mid-release discards everything, with no partial pulse.
- Parser FSM: IDLE -> HDR1 on rx_st_vc0 (capture word0); HDR1 -> BODY (capture word1); BODY -> IDLE on rx_end_vc0.
- Word0[14:13] = Fmt, word0[12:8] = Type. Word1[9:0] = Length (DW).
- Classification:
  - Posted: Type 00000 with Fmt[1]=1 (MWr), or Type 10xxx (Msg/MsgD).
  - Non-posted: MRd, MRdLk, IO, Cfg.
  - Cpl/CplD: not enqueued (infinite credits).
  - Other types: treated as posted header only.
- Data credits: ceil(Length/4) when Fmt[1]=1, else 0. Length 0 means 1024 DW, i.e. 256 credits. Non-posted data credits are always 1.
- Enqueue occurs in the rx_end_vc0 cycle with entry {class, hdr, dcred[8:0], auto}.
  - auto = 1 if rx_us_req_vc0 or rx_malf_tlp_vc0 was seen at any point in the packet.
- rx_st_vc0 outside IDLE: set seq_err, drop the partial TLP, restart capture. rx_end_vc0 in IDLE or HDR1: set seq_err, ignore.
- Queue full at enqueue: TLP dropped, ovf_err set (sticky until reset).
- Release: head entry is retired when (auto=1) or (tlp_release=1 and auto=0). tlp_release with an empty queue or an auto head is ignored.
- Retirement outputs are registered, 1 cycle after the retire condition; each pulse lasts 1 cycle.
  - Posted: ph_processed and, if dcred > 0, pd_processed with pd_num = dcred.
  - Non-posted: nph_processed, plus npd_processed with npd_num = 1 for write types.
- dcred = 256: pd_num = 128 with the header pulse, then pd_processed with pd_num = 128 the next cycle. The head is busy for 2 cycles, and tlp_release during that time is held pending.
- At most one retirement per cycle; num outputs return to 0 when no pulse.
- Simultaneous enqueue and retire: occupancy unchanged and both take effect.
- buf_status = (pending_cnt >= AFULL_LVL), registered.

Decomposition:
- Package pcie_x1_rx_pkg: Fmt/Type codes, class enum {POSTED, NONPOSTED}, entry struct, credit width constant.
- One sub-module, pcie_x1_rx_credit_fifo: synchronous FIFO with count, full and empty.

Test Plan:
- MWr, Length 4, then tlp_release -> one cycle later ph_processed = 1, pd_processed = 1, pd_num = 1. No nph/npd pulses.
- MRd, Length 16, then release -> nph_processed only, npd_num = 0. CfgWr0 then release -> nph_processed + npd_processed, npd_num = 1.
- MWr, Length 0 -> ph_processed + pd_num = 128 in cycle N, pd_num = 128 in cycle N+1. A second TLP's release issued in cycle N retires in cycle N+2.
- CplD received -> pending_cnt stays 0, no pulses. Then 7 MWr with no releases -> buf_status = 1 at count 7. 9th MWr with DEPTH = 8 -> ovf_err = 1, count 8.
- Malformed MRd followed by normal MWr -> MRd auto-retires (nph pulse) with no tlp_release; MWr waits for release.
- rx_st_vc0 asserted in BODY -> seq_err = 1, first TLP not enqueued. Assert rst_n low mid-TLP -> all outputs 0, queue empty.
